// File: rtl/tx_filter_pkg.sv
// Shared constants for the transmit pulse shaper, BER checker and PRBS9 top.
//   OS, N_BAUD            : oversampling factor and filter span in symbols
//   NB_/NBF_OUTPUT        : output sample format S(8,7)
//   NB_/NBF_COEFF         : coefficient format S(8,7)
//   RC_COEFFS             : default raised-cosine taps (rolloff 0.5), tap n at [n*8 +: 8]
//   SYM_POS_BIT/NEG_BIT   : bit value that maps to +1 / -1
package tx_filter_pkg;

  localparam int unsigned OS         = 4;
  localparam int unsigned N_BAUD     = 6;
  localparam int unsigned NB_OUTPUT  = 8;
  localparam int unsigned NBF_OUTPUT = 7;
  localparam int unsigned NB_COEFF   = 8;
  localparam int unsigned NBF_COEFF  = 7;

  localparam int unsigned NB_COEFF_VEC = N_BAUD * OS * NB_COEFF;

  // Taps 23 down to 0 (MSB first): 1,2,3,0,-7,-15,-16,0,34,77,114,127,114,77,34,0,-16,-15,-7,0,3,2,1,0
  localparam logic [NB_COEFF_VEC-1:0] RC_COEFFS =
    192'h01020300F9F1F000224D727F724D2200F0F1F90003020100;

  localparam logic SYM_POS_BIT = 1'b0;
  localparam logic SYM_NEG_BIT = 1'b1;

endpackage

// File: rtl/sat_trunc.sv
// Signed width reduction: drop NB_DROP LSBs (floor), then saturate or wrap to NB_OUT.
// Saturation is built when TX_RC_FILTER_SAT_EN is defined; otherwise two's-complement wrap.
//   i_data   : NB_IN-bit signed input
//   o_data_c : NB_OUT-bit signed result (combinational)
module sat_trunc #(
  parameter int unsigned NB_IN   = 11,
  parameter int unsigned NB_OUT  = 8,
  parameter int unsigned NB_DROP = 0
) (
  input  logic [NB_IN-1:0]  i_data,
  output logic [NB_OUT-1:0] o_data_c
);

  localparam int unsigned NB_MID = NB_IN - NB_DROP;

  // Taking the upper bits of a two's-complement value is truncation toward -inf.
  logic [NB_MID-1:0] w_mid;
  assign w_mid = i_data[NB_IN-1:NB_DROP];

  generate
    if (NB_DROP > 0) begin : g_drop
      logic w_unused_lsb;
      assign w_unused_lsb = ^i_data[NB_DROP-1:0];
    end
  endgenerate

`ifdef TX_RC_FILTER_SAT_EN
  // In range when every bit from the output sign upward agrees.
  logic w_in_range;
  assign w_in_range = (&w_mid[NB_MID-1:NB_OUT-1]) | ~(|w_mid[NB_MID-1:NB_OUT-1]);

  always_comb begin
    o_data_c = w_mid[NB_OUT-1:0];
    if (!w_in_range) begin
      o_data_c = w_mid[NB_MID-1] ? {1'b1, {(NB_OUT-1){1'b0}}}
                                 : {1'b0, {(NB_OUT-1){1'b1}}};
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^w_mid[NB_MID-1:NB_OUT];
  assign o_data_c    = w_mid[NB_OUT-1:0];
`endif

endmodule

// File: rtl/tx_rc_polyphase_filter.sv
// Polyphase raised-cosine pulse shaper, OS samples per symbol, multiplier-free (+/-1 symbols).
// Optional output saturation: define TX_RC_FILTER_SAT_EN (default build wraps).
//   clk      : system clock
//   i_rst_n  : synchronous active-low reset
//   i_en     : clock enable, low freezes state and o_data
//   i_valid  : symbol strobe, also resynchronises the phase counter
//   i_data   : symbol bit (0 -> +1, 1 -> -1)
//   o_data   : shaped sample, signed S(NB_OUTPUT,NBF_OUTPUT)
//   o_valid  : registered copy of i_en
module tx_rc_polyphase_filter
  import tx_filter_pkg::*;
#(
  parameter int unsigned NB_OUTPUT  = tx_filter_pkg::NB_OUTPUT,
  parameter int unsigned NBF_OUTPUT = tx_filter_pkg::NBF_OUTPUT,
  parameter int unsigned NB_COEFF   = tx_filter_pkg::NB_COEFF,
  parameter int unsigned NBF_COEFF  = tx_filter_pkg::NBF_COEFF,
  parameter int unsigned N_BAUD     = tx_filter_pkg::N_BAUD,
  parameter int unsigned OS         = tx_filter_pkg::OS,
  parameter logic [N_BAUD*OS*NB_COEFF-1:0] COEFFS = tx_filter_pkg::RC_COEFFS
) (
  input  logic                 clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_valid,
  input  logic                 i_data,
  output logic [NB_OUTPUT-1:0] o_data,
  output logic                 o_valid
);

  localparam int unsigned NB_PHASE = $clog2(OS);
  localparam int unsigned NB_ACC   = NB_COEFF + $clog2(N_BAUD);
  localparam int unsigned NB_DROP  = NBF_COEFF - NBF_OUTPUT;

  logic [N_BAUD-1:0]    r_sym;
  logic [N_BAUD-1:0]    r_occ;
  logic [NB_PHASE-1:0]  r_phase;
  logic [NB_OUTPUT-1:0] r_data;
  logic                 r_valid;

  logic signed [NB_ACC-1:0]   w_acc;
  logic signed [NB_COEFF-1:0] w_tap;
  logic signed [NB_ACC-1:0]   w_ext;
  logic [NB_OUTPUT-1:0]       w_sample;

  // One phase column of the coefficient set, signed by the stored symbol.
  always_comb begin
    w_acc = '0;
    w_tap = '0;
    w_ext = '0;
    for (int k = 0; k < int'(N_BAUD); k++) begin
      w_tap = $signed(COEFFS[(k*int'(OS) + int'(r_phase))*int'(NB_COEFF) +: NB_COEFF]);
      w_ext = NB_ACC'(w_tap);
      if (r_occ[k]) begin
        w_acc = (r_sym[k] == SYM_NEG_BIT) ? (w_acc - w_ext) : (w_acc + w_ext);
      end
    end
  end

  sat_trunc #(
    .NB_IN   (NB_ACC),
    .NB_OUT  (NB_OUTPUT),
    .NB_DROP (NB_DROP)
  ) u_sat_trunc (
    .i_data   (w_acc),
    .o_data_c (w_sample)
  );

  // Symbol/occupancy shift, phase counter and output register.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_sym   <= '0;
      r_occ   <= '0;
      r_phase <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_en;
      if (i_en) begin
        r_data <= w_sample;
        if (i_valid) begin
          r_sym   <= {r_sym[N_BAUD-2:0], i_data};
          r_occ   <= {r_occ[N_BAUD-2:0], 1'b1};
          r_phase <= '0;
        end else if (r_phase == NB_PHASE'(OS-1)) begin
          r_phase <= '0;
        end else begin
          r_phase <= r_phase + NB_PHASE'(1);
        end
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: tb/tb_tx_rc_polyphase_filter.sv
// Self-checking bench: directed test-plan scenarios plus random traffic against a
// symbol-history reference model.
module tb_tx_rc_polyphase_filter;

  localparam int OS     = 4;
  localparam int N_BAUD = 6;

  logic       clk = 1'b0;
  logic       rst_n, en, valid, din;
  logic [7:0] dout;
  logic       vout;

  always #5 clk = ~clk;

  tx_rc_polyphase_filter dut (
    .clk     (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_valid (valid),
    .i_data  (din),
    .o_data  (dout),
    .o_valid (vout)
  );

  int coef [24] = '{0, 1, 2, 3, 0, -7, -15, -16, 0, 34, 77, 114,
                    127, 114, 77, 34, 0, -16, -15, -7, 0, 3, 2, 1};

  // Model state: symbol history as +1/-1 (0 = empty slot), current phase.
  int hist [N_BAUD];
  int phase;
  int exp_d, exp_v;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int expv);
    n_checks++;
    if (obs != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  function automatic int to_out(input int acc);
`ifdef TX_RC_FILTER_SAT_EN
    if (acc > 127)  return 127;
    if (acc < -128) return -128;
    return acc;
`else
    int w;
    w = acc % 256;
    if (w < 0)   w += 256;
    if (w > 127) w -= 256;
    return w;
`endif
  endfunction

  function automatic int model_acc();
    int s = 0;
    for (int k = 0; k < N_BAUD; k++) s += hist[k] * coef[k*OS + phase];
    return s;
  endfunction

  // Apply inputs for one clock, advance the model at the edge, compare just after.
  task automatic tick(input logic r, input logic e, input logic v, input logic d);
    rst_n = r; en = e; valid = v; din = d;
    @(posedge clk);
    if (!r) begin
      for (int k = 0; k < N_BAUD; k++) hist[k] = 0;
      phase = 0; exp_d = 0; exp_v = 0;
    end else begin
      exp_v = int'(e);
      if (e) begin
        exp_d = to_out(model_acc());
        if (v) begin
          for (int k = N_BAUD-1; k > 0; k--) hist[k] = hist[k-1];
          hist[0] = d ? -1 : 1;
          phase = 0;
        end else begin
          phase = (phase + 1) % OS;
        end
      end
    end
    #1;
    check_eq("o_data", $signed(dout), exp_d);
    check_eq("o_valid", int'(vout), exp_v);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b1);
  endtask

  // Constant symbol stream; capture one steady-state symbol period by phase.
  task automatic steady(input logic d, input int e0, input int e1, input int e2, input int e3);
    int got [4];
    do_reset();
    for (int g = 0; g < 8; g++)
      for (int j = 0; j < 4; j++) begin
        tick(1'b1, 1'b1, j == 0, d);
        if (g == 7) got[(j+3) % 4] = $signed(dout);
      end
    check_eq("steady_p0", got[0], e0);
    check_eq("steady_p1", got[1], e1);
    check_eq("steady_p2", got[2], e2);
    check_eq("steady_p3", got[3], e3);
  endtask

  initial begin
    int  imp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int  held;
    logic sent [16];

    rst_n = 1'b0; en = 1'b0; valid = 1'b0; din = 1'b0;
    do_reset();
    check_eq("rst_data", $signed(dout), 0);
    check_eq("rst_valid", int'(vout), 0);

    // Single +1 symbol: impulse response columns, repeating while the phase wraps.
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      check_eq("impulse", $signed(dout), imp[i]);
    end

`ifdef TX_RC_FILTER_SAT_EN
    steady(1'b0, 127, 127, 127, 127);
    steady(1'b1, -127, -128, -128, -128);
`else
    steady(1'b0, 127, -127, -128, -127);
    steady(1'b1, -127, 127, -128, 127);
`endif

    // Alternating symbols: phase 0 is the centre tap, carrying the bit from 3 symbols back.
    do_reset();
    for (int n = 0; n < 12; n++) begin
      sent[n] = n[0];
      tick(1'b1, 1'b1, 1'b1, sent[n]);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      if (n >= 5) begin
        check_eq("alt_val", $signed(dout), sent[n-3] ? -127 : 127);
        check_eq("alt_msb", int'(dout[7]), int'(sent[n-3]));
      end
      tick(1'b1, 1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0, 1'b0);
    end

    // Enable dropped mid-stream: output frozen, o_valid low, phase held.
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    held = $signed(dout);
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 1'b0, i == 2, 1'b1);
      check_eq("freeze_data", $signed(dout), held);
      check_eq("freeze_valid", int'(vout), 0);
    end
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);

    // Early strobe at phase 2 resynchronises to phase 0.
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);

    // One-clock reset mid-stream; the next sample comes from an empty register.
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("midrst_data", $signed(dout), 0);
    check_eq("midrst_valid", int'(vout), 0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("post_rst", $signed(dout), 0);

    // Random traffic: enable gaps, irregular strobes, rare resets.
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 299) != 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 3) == 0,
           1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_rc_polyphase_filter.md
Name: tx_rc_polyphase_filter

Overview:
- Transmit-side pulse shaper directly upstream of the BER checker.
- Takes one PRBS9 bit per symbol and produces an oversampled (OS=4) raised-cosine waveform, one sample per enabled clock.
- Output format matches the checker's input: signed, slicer on MSB.
- Polyphase form: each clock evaluates one phase column of the coefficient set; no multipliers, because symbols are ±1.

Parameters:
- NB_OUTPUT, 8, output width.
- NBF_OUTPUT, 7, output fractional bits.
- NB_COEFF, 8, coefficient width, signed.
- NBF_COEFF, 7, coefficient fractional bits.
- N_BAUD, 6, filter span in symbols.
- OS, 4, oversampling factor (samples per symbol).
- COEFFS, packed N_BAUD*OS*NB_COEFF bits, tap n at bits [n*NB_COEFF +: NB_COEFF].
  - Default is RC, rolloff 0.5, S(8,7), taps 0..23: 0,1,2,3,0,-7,-15,-16,0,34,77,114,127,114,77,34,0,-16,-15,-7,0,3,2,1.

Ports:
- clk, input, 1, system clock.
- i_rst_n, input, 1, synchronous active-low reset.
- i_en, input, 1, enable; low freezes all state and outputs.
- i_valid, input, 1, symbol strobe, nominally every OS enabled clocks.
- i_data, input, 1, symbol bit; 0 maps to +1, 1 maps to -1.
- o_data, output, NB_OUTPUT, shaped sample, signed S(NB_OUTPUT,NBF_OUTPUT).
- o_valid, output, 1, registered copy of i_en.

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - sym_reg and occ_mask are cleared; phase_cnt=0; o_data=0; o_valid=0.
  - A reset mid-operation aborts immediately; the next sample is computed from the empty register.
- Symbol register: N_BAUD bits; sym_reg[0] is the newest. occ_mask is N_BAUD bits.
  - On i_en && i_valid: sym_reg <= {sym_reg[N_BAUD-2:0], i_data} and occ_mask <= {occ_mask[N_BAUD-2:0], 1}.
  - Slots with occ_mask=0 contribute 0.
- Phase counter (width clog2(OS)):
  - On i_en && i_valid: phase_cnt <= 0. i_valid therefore resynchronises the phase and early or late strobes are legal.
  - Otherwise, on i_en: phase_cnt increments, wrapping from OS-1 to 0.
  - A simultaneous i_valid and wrap resolves to 0; no conflict.
- Datapath:
  - acc = sum over k=0..N_BAUD-1 of occ[k] ? (sym[k] ? -c[k*OS+p] : +c[k*OS+p]) : 0, where p = phase_cnt, using current register values before any update.
  - acc width is NB_COEFF+clog2(N_BAUD) = 11 bits, signed, exact.
  - Alignment: drop (NBF_COEFF-NBF_OUTPUT) LSBs by truncation toward -inf; with the defaults nothing is dropped.
  - Output conversion follows the optional feature (saturate or wrap).
- Latency: o_data is registered on i_en, one clock after the phase/symbol state it reflects.
  - Sample at phase p of a symbol loaded at edge T appears at edge T+1+p.
- i_en=0: no shift, no phase advance, o_data holds, o_valid=0 next edge.
- i_valid while i_en=0: ignored.

Optional Feature:
- Macro TX_RC_FILTER_SAT_EN.
- Defined: acc outside [-2^(NB_OUTPUT-1), 2^(NB_OUTPUT-1)-1] clamps to -128 or +127.
- Undefined: the low NB_OUTPUT bits of acc are taken (two's-complement wrap); saves comparators.

Decomposition:
- Shared include/package tx_filter_pkg:
  - OS, N_BAUD, NB_OUTPUT/NBF_OUTPUT, NB_COEFF/NBF_COEFF;
  - default RC coefficient vector;
  - symbol mapping constants.
- These are shared with the BER checker and the PRBS9 top level.
- One sub-module, sat_trunc: parameterised width reduction (truncate plus saturate or wrap), reused by the receive FIR.

Test Plan:
- Reset, then i_en=1, one i_valid with i_data=0, then i_valid low → o_data over the next 4 enabled clocks = 0,1,2,3, then repeats 0,1,2,3 (phase wraps, register unchanged).
- Continuous i_data=0 with i_valid every 4 clocks, after 6 symbols, SAT_EN defined → steady o_data per phase = 127,127,127,127 (raw 127,129,128,129).
- Same with i_data=1 → -127,-128,-128,-128.
- Same with SAT_EN undefined → +1 case gives 127,-127,-128,-127.
- Alternating 0/1 symbols, full register, phase 0 → o_data = ±127 alternating per symbol; MSB equals the bit sent 3 symbols earlier (centre tap k=3).
- Drop i_en for 5 clocks mid-stream → o_data frozen, o_valid=0; on resume the sequence continues at the held phase.
- Early i_valid at phase 2 → next output uses phase 0 with the new symbol.
- Assert i_rst_n=0 for one clock mid-stream → o_data=0, o_valid=0; first following sample is 0 (empty occ_mask).
